// File: rtl/yuv422_packer_if.sv
// AXI-Stream bundle used on both sides of the 4:4:4 -> 4:2:2 packer.
// The master drives payload and valid; the slave drives ready.
interface yuv422_packer_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tuser;
  logic         tlast;

  modport master (
    output tdata, tvalid, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/yuv422_packer.sv
// Packs 4:4:4 YUV pixels into 4:2:2 beats, averaging chroma per pair.
// Emits one beat pair per input pair; lone pixels at line end are doubled.
module yuv422_packer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic aclk,
  input  logic areset,
  yuv422_packer_if.slave  s_axis,
  yuv422_packer_if.master m_axis,
  output logic resync_err
);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_EVEN,
    S_ODD,
    S_OUT0,
    S_OUT1
  } state_t;

  state_t st, st_n;

  logic          run;
  logic [DW-1:0] ye, ue, ve;
  logic          eu;
  logic [2*DW-1:0] b0, b1;
  logic          bu, bl;
  logic [DW-1:0] yi, ui, vi;
  logic [DW:0]   us, vs;
  logic          s_rdy, s_acc;
  logic          take_e, mk_pair;
  logic          mk_lone, resync;

  assign yi = s_axis.tdata[DW-1:0];
  assign ui = s_axis.tdata[2*DW-1:DW];
  assign vi = s_axis.tdata[3*DW-1:2*DW];

  // one extra bit keeps the rounded sum from wrapping
  assign us = {1'b0, ue} + {1'b0, ui}
            + {{DW{1'b0}}, 1'b1};
  assign vs = {1'b0, ve} + {1'b0, vi}
            + {{DW{1'b0}}, 1'b1};

  always_comb begin
    s_rdy = 1'b0;
    unique case (st)
      S_EVEN: s_rdy = run;
      S_ODD:  s_rdy = run;
      S_OUT0: s_rdy = 1'b0;
      S_OUT1: s_rdy = m_axis.tready;
    endcase
  end

  assign s_acc = s_axis.tvalid & s_rdy;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st         <= S_EVEN;
      run        <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      st         <= st_n;
      run        <= 1'b1;
      resync_err <= resync;
    end
  end

  always_comb begin
    st_n    = st;
    take_e  = 1'b0;
    mk_pair = 1'b0;
    mk_lone = 1'b0;
    resync  = 1'b0;
    unique case (st)
      S_EVEN: begin
        if (s_acc) begin
          take_e = 1'b1;
          mk_lone = s_axis.tlast;
          st_n = s_axis.tlast ? S_OUT0 : S_ODD;
        end
      end
      S_ODD: begin
        if (s_acc && s_axis.tuser) begin
          resync = 1'b1;
          take_e = 1'b1;
          mk_lone = s_axis.tlast;
          st_n = s_axis.tlast ? S_OUT0 : S_ODD;
        end else if (s_acc) begin
          mk_pair = 1'b1;
          st_n = S_OUT0;
        end
      end
      S_OUT0: begin
        if (m_axis.tready) st_n = S_OUT1;
      end
      S_OUT1: begin
        if (s_acc) begin
          take_e = 1'b1;
          mk_lone = s_axis.tlast;
          st_n = s_axis.tlast ? S_OUT0 : S_ODD;
        end else if (m_axis.tready) begin
          st_n = S_EVEN;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ye <= '0;
      ue <= '0;
      ve <= '0;
      eu <= 1'b0;
      b0 <= '0;
      b1 <= '0;
      bu <= 1'b0;
      bl <= 1'b0;
    end else begin
      if (take_e) begin
        ye <= yi;
        ue <= ui;
        ve <= vi;
        eu <= s_axis.tuser;
      end
      if (mk_pair) begin
        b0 <= {us[DW:1], ye};
        b1 <= {vs[DW:1], yi};
        bu <= eu;
        bl <= s_axis.tlast;
      end else if (mk_lone) begin
        b0 <= {ui, yi};
        b1 <= {vi, yi};
        bu <= s_axis.tuser;
        bl <= 1'b1;
      end
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = (st == S_OUT0)
                       | (st == S_OUT1);
  assign m_axis.tuser  = (st == S_OUT0) & bu;
  assign m_axis.tlast  = (st == S_OUT1) & bl;

  always_comb begin
    m_axis.tdata = '0;
    unique case (st)
      S_EVEN: m_axis.tdata = '0;
      S_ODD:  m_axis.tdata = '0;
      S_OUT0: m_axis.tdata = b0;
      S_OUT1: m_axis.tdata = b1;
    endcase
  end
endmodule

// File: tb/tb_yuv422_packer.sv
// Bench for yuv422_packer: queue-based pairing model plus directed cases.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_yuv422_packer;
  typedef struct {
    int y;
    int u;
    int v;
    bit user;
    bit last;
  } pix_t;

  typedef struct {
    logic [15:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic resync_err;

  yuv422_packer_if #(.W(24)) s_if ();
  yuv422_packer_if #(.W(16)) m_if ();

  yuv422_packer #(.DATA_WIDTH(8)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .resync_err (resync_err)
  );

  always #5 aclk = ~aclk;

  int    n_cmp = 0;
  int    n_bad = 0;
  pix_t  pix_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    vld_pct = 100;
  int    rdy_pct = 100;
  bit    s_hs = 0;
  bit    have_e = 0;
  pix_t  e;
  bit    exp_rs = 0;
  int    rs_cnt = 0;
  int    cyc = 0;
  int    first_acc = -1;
  int    last_beat = 0;
  int    beat_cnt = 0;
  int    tlast_cnt = 0;
  bit    pstall = 0;
  beat_t pb;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  function automatic beat_t mk(int c, int y,
                               bit u, bit l);
    beat_t b;
    b.d = {c[7:0], y[7:0]};
    b.u = u;
    b.l = l;
    return b;
  endfunction

  // Spec-level pairing: even+odd -> averaged pair,
  // lone line-end pixel -> doubled, SOF mid-pair -> resync.
  task automatic model_accept(input pix_t p);
    if (!have_e) begin
      if (p.last) begin
        exp_q.push_back(mk(p.u, p.y, p.user, 0));
        exp_q.push_back(mk(p.v, p.y, 0, 1));
      end else begin
        e = p;
        have_e = 1;
      end
    end else if (p.user) begin
      exp_rs = 1;
      if (p.last) begin
        exp_q.push_back(mk(p.u, p.y, 1, 0));
        exp_q.push_back(mk(p.v, p.y, 0, 1));
        have_e = 0;
      end else begin
        e = p;
      end
    end else begin
      exp_q.push_back(mk((e.u + p.u + 1) / 2,
                         e.y, e.user, 0));
      exp_q.push_back(mk((e.v + p.v + 1) / 2,
                         p.y, 0, p.last));
      have_e = 0;
    end
  endtask

  // driver
  initial begin
    pix_t p;
    s_if.tvalid = 0;
    s_if.tdata  = '0;
    s_if.tuser  = 0;
    s_if.tlast  = 0;
    m_if.tready = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (s_hs && pix_q.size() > 0)
        void'(pix_q.pop_front());
      if (pix_q.size() == 0) begin
        s_if.tvalid = 0;
      end else if (!(s_if.tvalid && !s_hs)) begin
        s_if.tvalid =
          ($urandom_range(0, 99) < vld_pct);
      end
      if (pix_q.size() > 0) begin
        p = pix_q[0];
        s_if.tdata = {p.v[7:0], p.u[7:0], p.y[7:0]};
        s_if.tuser = p.user;
        s_if.tlast = p.last;
      end
      m_if.tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // monitor / compare
  initial begin
    pix_t  p;
    beat_t b;
    beat_t x;
    forever begin
      @(negedge aclk);
      cyc++;
      if (areset) begin
        have_e = 0;
        exp_q.delete();
        exp_rs = 0;
        s_hs = 0;
        pstall = 0;
      end else begin
        chk("resync_err", resync_err, exp_rs);
        if (resync_err) rs_cnt++;
        if (pstall) begin
          chk("hold_valid", m_if.tvalid, 1);
          chk("hold_data", m_if.tdata, pb.d);
          chk("hold_user", m_if.tuser, pb.u);
          chk("hold_last", m_if.tlast, pb.l);
        end
        if (m_if.tvalid && m_if.tready) begin
          b.d = m_if.tdata;
          b.u = m_if.tuser;
          b.l = m_if.tlast;
          got_q.push_back(b);
          beat_cnt++;
          last_beat = cyc;
          if (b.l) tlast_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL extra_beat: got %0h want none",
                     b.d);
          end else begin
            n_cmp--;
            x = exp_q.pop_front();
            chk("beat_data", b.d, x.d);
            chk("beat_user", b.u, x.u);
            chk("beat_last", b.l, x.l);
          end
        end
        s_hs = s_if.tvalid && s_if.tready;
        exp_rs = 0;
        if (s_hs) begin
          if (first_acc < 0) first_acc = cyc;
          p.y = s_if.tdata[7:0];
          p.u = s_if.tdata[15:8];
          p.v = s_if.tdata[23:16];
          p.user = s_if.tuser;
          p.last = s_if.tlast;
          model_accept(p);
        end
        pstall = m_if.tvalid && !m_if.tready;
        pb.d = m_if.tdata;
        pb.u = m_if.tuser;
        pb.l = m_if.tlast;
      end
    end
  end

  task automatic push(int y, int u, int v,
                      bit user, bit last);
    pix_t p;
    p.y = y;
    p.u = u;
    p.v = v;
    p.user = user;
    p.last = last;
    pix_q.push_back(p);
  endtask

  task automatic add_line(int len, bit sof);
    for (int i = 0; i < len; i++) begin
      push($urandom_range(0, 255),
           $urandom_range(0, 255),
           $urandom_range(0, 255),
           (i == 0 && sof) ||
           (i > 0 && $urandom_range(0, 9) == 0),
           i == len - 1);
    end
  endtask

  task automatic wait_src(input string nm, int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge aclk);
      ok = (pix_q.size() == 0);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: source not drained in %0d",
               nm, lim);
    end
  endtask

  task automatic wait_idle(input string nm, int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge aclk);
      ok = pix_q.size() == 0 && exp_q.size() == 0
        && !s_if.tvalid && !m_if.tvalid;
    end
    repeat (3) @(negedge aclk);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: not idle in %0d cycles",
               nm, lim);
    end
  endtask

  task automatic chk_rst_outs(input string nm);
    chk({nm, "_s_rdy"}, s_if.tready, 0);
    chk({nm, "_m_vld"}, m_if.tvalid, 0);
    chk({nm, "_tdata"}, m_if.tdata, 0);
    chk({nm, "_tuser"}, m_if.tuser, 0);
    chk({nm, "_tlast"}, m_if.tlast, 0);
    chk({nm, "_resync"}, resync_err, 0);
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    chk_rst_outs("rst");
    @(posedge aclk);
    #3 areset = 0;
    @(negedge aclk);
    chk("rdy_before_edge", s_if.tready, 0);
    @(negedge aclk);
    chk("rdy_after_edge", s_if.tready, 1);

    // basic pair with SOF
    got_q.delete();
    push(8'h10, 8'h80, 8'h40, 1, 0);
    push(8'h20, 8'h81, 8'h43, 0, 1);
    wait_idle("pair", 200);
    chk("pair_cnt", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("pair_b0", got_q[0].d, 16'h8110);
      chk("pair_b0u", got_q[0].u, 1);
      chk("pair_b0l", got_q[0].l, 0);
      chk("pair_b1", got_q[1].d, 16'h4220);
      chk("pair_b1u", got_q[1].u, 0);
      chk("pair_b1l", got_q[1].l, 1);
    end

    // backpressure in first output beat
    got_q.delete();
    rdy_pct = 0;
    push(8'h30, 8'h10, 8'hf0, 0, 0);
    push(8'h31, 8'h20, 8'hff, 0, 1);
    wait_src("bp_src", 200);
    repeat (5) begin
      @(negedge aclk);
      chk("bp_s_rdy", s_if.tready, 0);
      chk("bp_m_vld", m_if.tvalid, 1);
      chk("bp_b0", m_if.tdata, 16'h1830);
    end
    rdy_pct = 100;
    wait_idle("bp", 200);
    chk("bp_cnt", got_q.size(), 2);
    if (got_q.size() == 2)
      chk("bp_b1", got_q[1].d, 16'hf831);

    // odd-length line of three
    got_q.delete();
    push(1, 8'h80, 8'h80, 0, 0);
    push(2, 8'h80, 8'h80, 0, 0);
    push(3, 8'h80, 8'h80, 0, 1);
    wait_idle("odd", 200);
    chk("odd_cnt", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("odd_b0", got_q[0].d, 16'h8001);
      chk("odd_b1", got_q[1].d, 16'h8002);
      chk("odd_b2", got_q[2].d, 16'h8003);
      chk("odd_b3", got_q[3].d, 16'h8003);
      chk("odd_l2", got_q[2].l, 0);
      chk("odd_l3", got_q[3].l, 1);
    end

    // SOF arriving while holding an even pixel
    got_q.delete();
    rs_cnt = 0;
    push(5, 8'h10, 8'h20, 0, 0);
    push(7, 8'h30, 8'h40, 1, 0);
    push(9, 8'h50, 8'h60, 0, 1);
    wait_idle("resync", 200);
    chk("rs_pulses", rs_cnt, 1);
    chk("rs_cnt", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("rs_b0", got_q[0].d, 16'h4007);
      chk("rs_b0u", got_q[0].u, 1);
      chk("rs_b1", got_q[1].d, 16'h5009);
    end

    // reset while the second beat is pending
    rdy_pct = 0;
    push(8'h11, 0, 0, 0, 0);
    push(8'h12, 0, 0, 0, 1);
    wait_src("rst_src", 200);
    @(posedge aclk);
    rdy_pct = 100;
    @(posedge aclk);
    rdy_pct = 0;
    @(negedge aclk);
    chk("out1_vld", m_if.tvalid, 1);
    chk("out1_data", m_if.tdata, 16'h0012);
    #2 areset = 1;
    @(negedge aclk);
    chk_rst_outs("mid_rst");
    @(posedge aclk);
    #3 areset = 0;
    got_q.delete();
    rdy_pct = 100;
    push(8'h21, 8'h02, 8'h06, 1, 0);
    push(8'h22, 8'h04, 8'h08, 0, 1);
    wait_idle("post_rst", 200);
    chk("prst_cnt", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("prst_b0", got_q[0].d, 16'h0321);
      chk("prst_b0u", got_q[0].u, 1);
    end

    // full 640-pixel line at full rate
    got_q.delete();
    first_acc = -1;
    beat_cnt = 0;
    tlast_cnt = 0;
    for (int i = 0; i < 640; i++)
      push($urandom_range(0, 255),
           $urandom_range(0, 255),
           $urandom_range(0, 255),
           i == 0, i == 639);
    wait_idle("line640", 3000);
    chk("l640_beats", beat_cnt, 640);
    chk("l640_tlast", tlast_cnt, 1);
    chk("l640_cycles", last_beat - first_acc, 960);
    if (got_q.size() == 640)
      chk("l640_lastl", got_q[639].l, 1);

    // random traffic with stalls on both sides
    vld_pct = 70;
    rdy_pct = 60;
    for (int k = 0; k < 40; k++)
      add_line($urandom_range(1, 9),
               $urandom_range(0, 3) == 0);
    wait_idle("random", 20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
